// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the SAP core: turns debounced button pulses into a registered
// clock enable and reset for cpu_main. The enable comes at a programmable rate.
module cpu_run_ctrl #(
    parameter int unsigned DIV_W        = 24,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             rst_req_i,
    input  logic             run_req_i,
    input  logic             stop_req_i,
    input  logic             step_req_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             halt_i,
    output logic             clk_en_o,
    output logic             cpu_reset_o,
    output logic [2:0]       state_o,
    output logic [15:0]      tick_count_o
);

    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_STOP = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rst_cnt;
    logic [DIV_W-1:0] presc;

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state        <= S_RST;
            rst_cnt      <= '0;
            presc        <= '0;
            tick_count_o <= '0;
            clk_en_o     <= 1'b0;
            cpu_reset_o  <= 1'b1;
        end else if (rst_req_i) begin
            // The request cycle already drives the first of the RESET_CYCLES reset cycles.
            state        <= (RESET_CYCLES == 1) ? S_STOP : S_RST;
            rst_cnt      <= CNT_W'(1);
            presc        <= '0;
            tick_count_o <= '0;
            clk_en_o     <= 1'b1;
            cpu_reset_o  <= 1'b1;
        end else begin
            clk_en_o    <= 1'b0;
            cpu_reset_o <= 1'b0;
            case (state)
                S_RST: begin
                    clk_en_o     <= 1'b1;
                    cpu_reset_o  <= 1'b1;
                    tick_count_o <= '0;
                    if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        state   <= S_STOP;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_req_i) begin
                        state <= S_STOP;
                    end else if (run_req_i) begin
                        state <= S_RUN;
                        presc <= '0;
                    end else if (step_req_i) begin
                        state        <= S_STEP;
                        clk_en_o     <= 1'b1;
                        tick_count_o <= tick_count_o + 16'd1;
                    end
                end
                S_RUN: begin
                    if (halt_i) begin
                        state <= S_HALT;
                    end else if (stop_req_i) begin
                        state <= S_STOP;
                    end else if (presc >= div_i) begin
                        // >= lets a lowered divider take effect without waiting for a wrap.
                        clk_en_o     <= 1'b1;
                        tick_count_o <= tick_count_o + 16'd1;
                        presc        <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_STEP: begin
                    state <= halt_i ? S_HALT : S_STOP;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Each step queues the outputs expected after the next edge,
// then compares them once that edge has passed.
module tb_cpu_run_ctrl;

    localparam int unsigned DIV_W = 24;
    localparam logic [2:0] ST_RST = 3'd0, ST_STOP = 3'd1, ST_RUN = 3'd2, ST_STEP = 3'd3,
                           ST_HALT = 3'd4;

    logic             clk = 1'b0;
    logic             reset_i, rst_req, run_req, stop_req, step_req, halt;
    logic [DIV_W-1:0] div;
    logic             clk_en, cpu_reset;
    logic [2:0]       state;
    logic [15:0]      tick;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DIV_W(DIV_W), .RESET_CYCLES(4)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .rst_req_i    (rst_req),
        .run_req_i    (run_req),
        .stop_req_i   (stop_req),
        .step_req_i   (step_req),
        .div_i        (div),
        .halt_i       (halt),
        .clk_en_o     (clk_en),
        .cpu_reset_o  (cpu_reset),
        .state_o      (state),
        .tick_count_o (tick)
    );

    task automatic step(input string tag, input logic en, input logic rst,
                        input logic [2:0] st, input logic [15:0] tk);
        exp_t        e;
        logic [20:0] obs;
        e.tag = tag;
        e.v   = {en, rst, st, tk};
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_req  = 1'b0;
        run_req  = 1'b0;
        stop_req = 1'b0;
        step_req = 1'b0;
        e   = sb.pop_front();
        obs = {clk_en, cpu_reset, state, tick};
        n_checks++;
        assert (obs === e.v) n_pass++;
        else $error("FAIL %s: observed en=%b rst=%b st=%0d tick=%h, expected en=%b rst=%b st=%0d tick=%h",
                    e.tag, obs[20], obs[19], obs[18:16], obs[15:0],
                    e.v[20], e.v[19], e.v[18:16], e.v[15:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_i = 1'b1; rst_req = 1'b0; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
        halt = 1'b0; div = '0;

        // Block reset, then the 4-cycle reset window with the enable held high.
        step("rst_hold", 0, 1, ST_RST, 0);
        step("rst_hold", 0, 1, ST_RST, 0);
        reset_i = 1'b0;
        repeat (3) step("rst_win", 1, 1, ST_RST, 0);
        step("rst_win_last", 1, 1, ST_STOP, 0);
        step("stop_idle", 0, 0, ST_STOP, 0);

        // Three single steps, five cycles apart.
        for (int i = 1; i <= 3; i++) begin
            step_req = 1'b1;
            step("step_pulse", 1, 0, ST_STEP, 16'(i));
            step("step_done", 0, 0, ST_STOP, 16'(i));
            repeat (3) step("step_gap", 0, 0, ST_STOP, 16'(i));
        end

        // run beats step; then rst_req out of RUN at div=5.
        div = 5;
        run_req = 1'b1; step_req = 1'b1;
        step("run_wins", 0, 0, ST_RUN, 3);
        repeat (5) step("run5_wait", 0, 0, ST_RUN, 3);
        step("run5_pulse", 1, 0, ST_RUN, 4);
        rst_req = 1'b1;
        step("rstreq_enter", 1, 1, ST_RST, 0);
        repeat (2) step("rstreq_win", 1, 1, ST_RST, 0);
        step("rstreq_last", 1, 1, ST_STOP, 0);
        step("rstreq_done", 0, 0, ST_STOP, 0);

        // div=3: one pulse every 4th cycle; stop lands on a would-be pulse cycle.
        div = 3;
        run_req = 1'b1;
        step("run3_start", 0, 0, ST_RUN, 0);
        for (int p = 1; p <= 10; p++) begin
            repeat (3) step("run3_wait", 0, 0, ST_RUN, 16'(p - 1));
            step("run3_pulse", 1, 0, ST_RUN, 16'(p));
        end
        repeat (3) step("run3_wait", 0, 0, ST_RUN, 10);
        stop_req = 1'b1;
        step("stop_suppress", 0, 0, ST_STOP, 10);
        repeat (5) step("stopped", 0, 0, ST_STOP, 10);

        // div=0 runs continuously until halt; HALT ignores run/step/stop.
        div = 0;
        run_req = 1'b1;
        step("run0_start", 0, 0, ST_RUN, 10);
        for (int i = 1; i <= 5; i++) step("run0_cont", 1, 0, ST_RUN, 16'(10 + i));
        halt = 1'b1;
        step("halt_enter", 0, 0, ST_HALT, 15);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) run_req = 1'b1;
            else step_req = 1'b1;
            if (i % 5 == 0) stop_req = 1'b1;
            step("halt_hold", 0, 0, ST_HALT, 15);
        end

        // rst_req leaves HALT; a second rst_req mid-window restarts the count.
        rst_req = 1'b1; halt = 1'b0;
        step("halt_rst", 1, 1, ST_RST, 0);
        step("halt_rst_win", 1, 1, ST_RST, 0);
        rst_req = 1'b1;
        step("rst_restart", 1, 1, ST_RST, 0);
        repeat (2) step("rst_restart_win", 1, 1, ST_RST, 0);
        step("rst_restart_last", 1, 1, ST_STOP, 0);
        step("rst_restart_done", 0, 0, ST_STOP, 0);

        // Tick counter wrap at div=0.
        run_req = 1'b1;
        step("wrap_start", 0, 0, ST_RUN, 0);
        idle(65534);
        step("wrap_ffff", 1, 0, ST_RUN, 16'hFFFF);
        step("wrap_zero", 1, 0, ST_RUN, 16'h0000);

        // Lowering div mid-count fires on the very next decision.
        div = 100;
        repeat (10) step("div100_wait", 0, 0, ST_RUN, 0);
        div = 2;
        step("div2_fast", 1, 0, ST_RUN, 1);
        repeat (2) step("div2_wait", 0, 0, ST_RUN, 1);
        step("div2_pulse", 1, 0, ST_RUN, 2);
        stop_req = 1'b1;
        step("final_stop", 0, 0, ST_STOP, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
